// File: rtl/keylime_cmd_pkg.sv
// rtl/keylime_cmd_pkg.sv - shared types and constants for the command initiator
package keylime_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_OP,
    ST_SEND_LEN,
    ST_SEND_PL,
    ST_SEND_CSUM,
    ST_WAIT_RESP,
    ST_DONE
  } cmd_state_t;

  localparam logic [7:0] STATUS_LEN_ERR = 8'hFE;
  localparam logic [7:0] STATUS_TIMEOUT = 8'hFF;

  // Frame: opcode, len, payload[0..len-1], checksum (XOR of all preceding bytes)
  localparam int         FRAME_OVERHEAD = 3;
  localparam logic [7:0] CSUM_INIT      = 8'h00;

endpackage

// File: rtl/cmd_payload_buf.sv
// rtl/cmd_payload_buf.sv - payload byte store with sync write and comb read
module cmd_payload_buf #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_LEN    = 16,
  parameter int ADDR_W     = 4
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [MAX_LEN];

  // No reset: contents deliberately persist across resets and commands.
  always_ff @(posedge clk) begin
    if (wr_en && (32'(wr_addr) < MAX_LEN)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = (32'(rd_addr) < MAX_LEN) ? mem[rd_addr] : '0;

endmodule

// File: rtl/cmd_initiator.sv
// rtl/cmd_initiator.sv - framed command sender with status reply wait and timeout
module cmd_initiator
  import keylime_cmd_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int MAX_LEN        = 16,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int LEN_W          = $clog2(MAX_LEN + 1),
  localparam int PL_AW         = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pl_wr_en,
  input  logic [PL_AW-1:0]      pl_wr_addr,
  input  logic [DATA_WIDTH-1:0] pl_wr_data,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DATA_WIDTH-1:0] cmd_opcode,
  input  logic [LEN_W-1:0]      cmd_len,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] status,
  output logic                  timeout
);

  localparam int              TO_W      = $clog2(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  cmd_state_t            state_q, state_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] csum_q, csum_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [LEN_W-1:0]      pl_idx_q, pl_idx_d;
  logic [TO_W-1:0]       wait_cnt_q, wait_cnt_d;
  logic [DATA_WIDTH-1:0] status_q, status_d;
  logic                  timeout_q, timeout_d;

  logic                  byte_accepted;
  logic [DATA_WIDTH-1:0] csum_next;
  logic [DATA_WIDTH-1:0] pl_rd_data;
  logic                  state_idle;

  assign state_idle = (state_q == ST_IDLE);

  cmd_payload_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .MAX_LEN    (MAX_LEN),
    .ADDR_W     (PL_AW)
  ) u_payload_buf (
    .clk     (clk),
    .wr_en   (pl_wr_en && state_idle),
    .wr_addr (pl_wr_addr),
    .wr_data (pl_wr_data),
    .rd_addr (pl_idx_q[PL_AW-1:0]),
    .rd_data (pl_rd_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      csum_q      <= CSUM_INIT;
      len_q       <= '0;
      pl_idx_q    <= '0;
      wait_cnt_q  <= '0;
      status_q    <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      csum_q      <= csum_d;
      len_q       <= len_d;
      pl_idx_q    <= pl_idx_d;
      wait_cnt_q  <= wait_cnt_d;
      status_q    <= status_d;
      timeout_q   <= timeout_d;
    end
  end

  // out_data always holds the byte on offer; the next byte is loaded on the
  // handshake so back-to-back bytes go out at one per cycle.
  always_comb begin
    state_d       = state_q;
    out_data_d    = out_data_q;
    out_valid_d   = out_valid_q;
    csum_d        = csum_q;
    len_d         = len_q;
    pl_idx_d      = pl_idx_q;
    wait_cnt_d    = wait_cnt_q;
    status_d      = status_q;
    timeout_d     = timeout_q;
    byte_accepted = out_valid_q && out_ready;
    csum_next     = csum_q ^ out_data_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          len_d     = cmd_len;
          csum_d    = CSUM_INIT;
          pl_idx_d  = '0;
          timeout_d = 1'b0;
          if (cmd_len > MAX_LEN_L) begin
            status_d = STATUS_LEN_ERR;
            state_d  = ST_DONE;
          end else begin
            out_data_d  = cmd_opcode;
            out_valid_d = 1'b1;
            state_d     = ST_SEND_OP;
          end
        end
      end
      ST_SEND_OP: begin
        if (byte_accepted) begin
          csum_d     = csum_next;
          out_data_d = DATA_WIDTH'(len_q);
          state_d    = ST_SEND_LEN;
        end
      end
      ST_SEND_LEN: begin
        if (byte_accepted) begin
          csum_d = csum_next;
          if (len_q == '0) begin
            out_data_d = csum_next;
            state_d    = ST_SEND_CSUM;
          end else begin
            out_data_d = pl_rd_data;
            pl_idx_d   = pl_idx_q + LEN_W'(1);
            state_d    = ST_SEND_PL;
          end
        end
      end
      ST_SEND_PL: begin
        // pl_idx_q counts payload bytes already loaded into out_data.
        if (byte_accepted) begin
          csum_d = csum_next;
          if (pl_idx_q == len_q) begin
            out_data_d = csum_next;
            state_d    = ST_SEND_CSUM;
          end else begin
            out_data_d = pl_rd_data;
            pl_idx_d   = pl_idx_q + LEN_W'(1);
          end
        end
      end
      ST_SEND_CSUM: begin
        if (byte_accepted) begin
          out_valid_d = 1'b0;
          out_data_d  = '0;
          wait_cnt_d  = '0;
          state_d     = ST_WAIT_RESP;
        end
      end
      ST_WAIT_RESP: begin
        // A reply arriving on the terminal count still wins over the timeout.
        if (in_valid) begin
          status_d  = in_data;
          timeout_d = 1'b0;
          state_d   = ST_DONE;
        end else if (wait_cnt_q == TO_LAST) begin
          status_d  = STATUS_TIMEOUT;
          timeout_d = 1'b1;
          state_d   = ST_DONE;
        end else begin
          wait_cnt_d = wait_cnt_q + TO_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Ready outputs are gated by rst_n so they stay low while reset is held.
  assign cmd_ready = rst_n && state_idle;
  assign in_ready  = rst_n && (state_idle || (state_q == ST_WAIT_RESP));
  assign busy      = !state_idle;
  assign done      = (state_q == ST_DONE);
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign status    = status_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_cmd_initiator.sv
// tb/tb_cmd_initiator.sv - scoreboard bench for cmd_initiator
module tb_cmd_initiator;

  localparam int MAX_LEN = 16;
  localparam int TO      = 64;
  localparam int LEN_W   = 5;
  localparam int AW      = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             pl_wr_en;
  logic [AW-1:0]    pl_wr_addr;
  logic [7:0]       pl_wr_data;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [7:0]       cmd_opcode;
  logic [LEN_W-1:0] cmd_len;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_ready;
  logic             busy;
  logic             done;
  logic [7:0]       status;
  logic             timeout;

  always #5 clk = ~clk;

  cmd_initiator #(
    .DATA_WIDTH     (8),
    .MAX_LEN        (MAX_LEN),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pl_wr_en   (pl_wr_en),
    .pl_wr_addr (pl_wr_addr),
    .pl_wr_data (pl_wr_data),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_opcode (cmd_opcode),
    .cmd_len    (cmd_len),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .busy       (busy),
    .done       (done),
    .status     (status),
    .timeout    (timeout)
  );

  int         vectors = 0;
  int         errors  = 0;
  logic [7:0] exp_q[$];
  logic [7:0] pl_model [MAX_LEN];
  bit         stall_prev = 1'b0;
  logic [7:0] stall_data;
  bit         valid_seen = 1'b0;

  // Stream scoreboard: every accepted byte is popped and compared; a stalled
  // byte must still be offered, unchanged, one cycle later.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (out_valid) valid_seen = 1'b1;
      if (stall_prev) begin
        vectors++;
        if (out_valid !== 1'b1 || out_data !== stall_data) begin
          errors++;
          $display("FAIL stall_hold: valid=%b data=%h, required valid=1 data=%h", out_valid, out_data, stall_data);
        end
      end
      if (out_valid && out_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL stream_extra: got byte %h, required none", out_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (out_data !== e) begin
            errors++;
            $display("FAIL stream_byte: got %h, required %h", out_data, e);
          end
        end
      end
      stall_prev = out_valid && !out_ready;
      stall_data = out_data;
    end else begin
      stall_prev = 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_pl(input int a, input logic [7:0] d);
    pl_wr_en   = 1'b1;
    pl_wr_addr = AW'(a);
    pl_wr_data = d;
    tick();
    pl_wr_en   = 1'b0;
    pl_model[a] = d;
  endtask

  task automatic push_frame(input logic [7:0] op, input int len);
    logic [7:0] cs;
    exp_q.push_back(op);
    exp_q.push_back(8'(len));
    cs = op ^ 8'(len);
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(pl_model[i]);
      cs = cs ^ pl_model[i];
    end
    exp_q.push_back(cs);
  endtask

  // Issues a command and runs until the whole frame has been accepted;
  // returns the number of cycles from command accept to WAIT_RESP entry.
  task automatic start_frame(input logic [7:0] op, input int len, input bit rnd, output int cycles);
    push_frame(op, len);
    cmd_valid  = 1'b1;
    cmd_opcode = op;
    cmd_len    = LEN_W'(len);
    tick();
    cmd_valid  = 1'b0;
    cycles     = 0;
    while ((out_valid || exp_q.size() != 0) && cycles < 300) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      cycles++;
    end
    out_ready = 1'b1;
    if (cycles >= 300) begin
      vectors++;
      errors++;
      $display("FAIL frame_bound: frame for op %h not finished after %0d cycles", op, cycles);
      exp_q.delete();
    end
  endtask

  task automatic send_reply(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    vectors++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_cmd_ready: got %b, required 0", cmd_ready); end
    vectors++; if (out_valid !== 1'b0 || out_data !== 8'h00) begin errors++; $display("FAIL rst_out: got valid=%b data=%h, required 0/00", out_valid, out_data); end
    vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b, required 0", in_ready); end
    vectors++; if ({busy, done, timeout} !== 3'b000 || status !== 8'h00) begin errors++; $display("FAIL rst_flags: got busy=%b done=%b timeout=%b status=%h, required 0/0/0/00", busy, done, timeout, status); end
    rst_n = 1'b1;
    #1;
    vectors++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b, required 1", cmd_ready); end
  endtask

  task automatic test_len0();
    int c;
    start_frame(8'h61, 0, 1'b0, c);
    vectors++; if (c !== 3) begin errors++; $display("FAIL len0_cycles: got %0d, required 3", c); end
    vectors++; if (in_ready !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL len0_wait: got in_ready=%b busy=%b, required 1/1", in_ready, busy); end
    send_reply(8'h00);
    vectors++; if (done !== 1'b1 || status !== 8'h00 || timeout !== 1'b0) begin errors++; $display("FAIL len0_done: got done=%b status=%h timeout=%b, required 1/00/0", done, status, timeout); end
    tick();
    vectors++; if (done !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL len0_idle: got done=%b cmd_ready=%b, required 0/1", done, cmd_ready); end
  endtask

  task automatic test_len3();
    int c;
    write_pl(0, 8'h01);
    write_pl(1, 8'h02);
    write_pl(2, 8'h03);
    start_frame(8'h62, 3, 1'b0, c);
    vectors++; if (c !== 6) begin errors++; $display("FAIL len3_cycles: got %0d, required 6", c); end
    send_reply(8'h5A);
    vectors++; if (done !== 1'b1 || status !== 8'h5A || timeout !== 1'b0) begin errors++; $display("FAIL len3_done: got done=%b status=%h timeout=%b, required 1/5a/0", done, status, timeout); end
    tick();
  endtask

  task automatic test_stall();
    int c;
    for (int r = 0; r < 3; r++) begin
      start_frame(8'h62, 3, 1'b1, c);
      vectors++; if (c < 6) begin errors++; $display("FAIL stall_cycles: got %0d, required >=6", c); end
      send_reply(8'hA5 + 8'(r));
      vectors++; if (done !== 1'b1 || status !== 8'hA5 + 8'(r)) begin errors++; $display("FAIL stall_done: got done=%b status=%h, required 1/%h", done, status, 8'hA5 + 8'(r)); end
      tick();
    end
  endtask

  task automatic test_timeout();
    int c;
    int n;
    start_frame(8'h63, 1, 1'b0, c);
    n = 0;
    while (!done && n < TO + 10) begin
      if (n == 2) begin
        pl_wr_en   = 1'b1;
        pl_wr_addr = '0;
        pl_wr_data = 8'hEE;
      end
      tick();
      pl_wr_en = 1'b0;
      n++;
    end
    vectors++; if (n !== TO) begin errors++; $display("FAIL timeout_latency: got %0d cycles, required %0d", n, TO); end
    vectors++; if (done !== 1'b1 || status !== 8'hFF || timeout !== 1'b1) begin errors++; $display("FAIL timeout_done: got done=%b status=%h timeout=%b, required 1/ff/1", done, status, timeout); end
    tick();
    vectors++; if (done !== 1'b0 || timeout !== 1'b1 || status !== 8'hFF) begin errors++; $display("FAIL timeout_hold: got done=%b timeout=%b status=%h, required 0/1/ff", done, timeout, status); end
  endtask

  task automatic test_reply_at_terminal();
    int c;
    start_frame(8'h64, 0, 1'b0, c);
    for (int n = 0; n < TO - 1; n++) tick();
    vectors++; if (done !== 1'b0) begin errors++; $display("FAIL term_early: got done=%b, required 0", done); end
    send_reply(8'hC3);
    vectors++; if (done !== 1'b1 || status !== 8'hC3 || timeout !== 1'b0) begin errors++; $display("FAIL term_reply_wins: got done=%b status=%h timeout=%b, required 1/c3/0", done, status, timeout); end
    tick();
  endtask

  task automatic test_len_err();
    valid_seen = 1'b0;
    cmd_valid  = 1'b1;
    cmd_opcode = 8'h65;
    cmd_len    = LEN_W'(17);
    tick();
    cmd_valid  = 1'b0;
    vectors++; if (done !== 1'b1 || status !== 8'hFE || busy !== 1'b1) begin errors++; $display("FAIL lenerr_done: got done=%b status=%h busy=%b, required 1/fe/1", done, status, busy); end
    tick();
    vectors++; if (done !== 1'b0 || cmd_ready !== 1'b1 || timeout !== 1'b0) begin errors++; $display("FAIL lenerr_idle: got done=%b cmd_ready=%b timeout=%b, required 0/1/0", done, cmd_ready, timeout); end
    vectors++; if (valid_seen !== 1'b0) begin errors++; $display("FAIL lenerr_no_frame: got out_valid seen=%b, required 0", valid_seen); end
    vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready: got %b, required 1", in_ready); end
    send_reply(8'h11);
    vectors++; if (status !== 8'hFE || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL stray_reply: got status=%h busy=%b done=%b, required fe/0/0", status, busy, done); end
  endtask

  task automatic test_reset_mid();
    int n;
    out_ready  = 1'b1;
    push_frame(8'h62, 3);
    cmd_valid  = 1'b1;
    cmd_opcode = 8'h62;
    cmd_len    = LEN_W'(3);
    tick();
    cmd_valid  = 1'b0;
    n = 0;
    while (exp_q.size() > 3 && n < 20) begin
      tick();
      n++;
    end
    vectors++; if (out_valid !== 1'b1 || out_data !== pl_model[1]) begin errors++; $display("FAIL mid_payload1: got valid=%b data=%h, required 1/%h", out_valid, out_data, pl_model[1]); end
    rst_n = 1'b0;
    exp_q.delete();
    tick();
    vectors++; if (out_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b0) begin errors++; $display("FAIL mid_reset: got valid=%b busy=%b cmd_ready=%b, required 0/0/0", out_valid, busy, cmd_ready); end
    rst_n = 1'b1;
    #1;
    vectors++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_release: got cmd_ready=%b, required 1", cmd_ready); end
  endtask

  task automatic test_after_reset();
    int c;
    start_frame(8'h62, 3, 1'b0, c);
    vectors++; if (c !== 6) begin errors++; $display("FAIL post_rst_cycles: got %0d, required 6", c); end
    send_reply(8'h77);
    vectors++; if (done !== 1'b1 || status !== 8'h77 || timeout !== 1'b0) begin errors++; $display("FAIL post_rst_done: got done=%b status=%h timeout=%b, required 1/77/0", done, status, timeout); end
    tick();
    vectors++; if (exp_q.size() !== 0) begin errors++; $display("FAIL scoreboard_left: got %0d bytes pending, required 0", exp_q.size()); end
  endtask

  initial begin
    rst_n      = 1'b0;
    pl_wr_en   = 1'b0;
    pl_wr_addr = '0;
    pl_wr_data = '0;
    cmd_valid  = 1'b0;
    cmd_opcode = '0;
    cmd_len    = '0;
    out_ready  = 1'b1;
    in_data    = '0;
    in_valid   = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) pl_model[i] = 8'h00;

    test_reset();
    test_len0();
    test_len3();
    test_stall();
    test_timeout();
    test_reply_at_terminal();
    test_len_err();
    test_reset_mid();
    test_after_reset();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/cmd_initiator.md
# cmd_initiator

Host-side command initiator for the control path: the requesting end of the byte-stream command protocol that the control logic serves. Accepts a command (opcode plus up to MAX_LEN payload bytes), serializes it as a framed byte stream on a valid/ready output into the control logic's receive side, then waits for the single-byte status reply on the control logic's transmit side. Used as the on-chip command source for bring-up, self-test sequences and system-level benches.

## Interface
- DATA_WIDTH, 8, byte width of both streams; only 8 is supported.
- MAX_LEN, 16, maximum payload bytes; 1..255.
- TIMEOUT_CYCLES, 1024, response wait limit in clk cycles; ≥2.
- LEN_W, $clog2(MAX_LEN+1), derived length width; not overridden.

- clk  in  1  single clock; all logic on posedge.
- rst_n  in  1  synchronous, active-low reset.
- pl_wr_en  in  1  payload buffer write strobe; ignored unless idle.
- pl_wr_addr  in  $clog2(MAX_LEN)  payload byte index.
- pl_wr_data  in  8  payload byte.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_opcode  in  8  opcode, e.g. 8'h61.
- cmd_len  in  LEN_W  payload byte count.
- out_data  out  8  frame byte toward the control logic rx input.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts.
- in_data  in  8  reply byte from the control logic tx output.
- in_valid  in  1  reply byte valid.
- in_ready  out  1  initiator accepts.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at command completion.
- status  out  8  reply byte or error code; holds until the next done.
- timeout  out  1  set with done when no reply arrived; cleared at the next command accept.

## Operation
- Frame format: opcode, len (zero-extended to 8 bits), payload[0..len-1], checksum. The checksum is the XOR of all preceding frame bytes.
- FSM states: IDLE, SEND_OP, SEND_LEN, SEND_PL, SEND_CSUM, WAIT_RESP, DONE.
- IDLE:
  - Writes to the payload buffer are allowed.
  - On cmd_valid & cmd_ready, latch opcode and len, clear the checksum accumulator, clear timeout.
  - If len > MAX_LEN, go to DONE with status 8'hFE; no frame bytes are emitted.
  - Otherwise go to SEND_OP.
- SEND_OP → SEND_LEN → SEND_PL, or SEND_CSUM directly when len==0. SEND_PL emits bytes with an index 0..len-1, then moves to SEND_CSUM. SEND_CSUM → WAIT_RESP.
- Each transition advances only on the cycle where out_valid & out_ready; the checksum accumulates the byte on that same cycle.
- WAIT_RESP:
  - in_ready=1 and a cycle counter increments.
  - The first accepted byte becomes status, then go to DONE.
  - If the counter reaches TIMEOUT_CYCLES-1 with no byte, set status=8'hFF and timeout=1, then go to DONE.
- DONE: done=1 for one cycle, then go to IDLE.
- In IDLE, in_ready=1 and stray reply bytes are accepted and discarded, so the control logic never stalls. In all other states except WAIT_RESP, in_ready=0.
- Payload writes while busy are ignored. Buffer contents persist across commands and are not cleared by reset.

## Timing
- Reset values: cmd_ready=0 during reset and 1 in the first cycle after reset; out_valid=0, out_data=0, in_ready=0 during reset; busy=0, done=0, status=0, timeout=0.
- out_data and out_valid are registered. The opcode appears with out_valid=1 in the cycle after command accept.
- Back-to-back bytes are supported at 1 byte/cycle when out_ready is held high. A len-N frame occupies N+3 cycles minimum.
- While out_valid=1 and out_ready=0, out_data is held stable and out_valid does not drop.
- Reply acceptance → done pulse in the next cycle. done → cmd_ready=1 in the following cycle, giving 2 cycles from reply to the next possible accept.
- Reply byte and timeout terminal count in the same cycle: the reply wins, status=in_data, timeout=0.
- Reset mid-frame: all state returns to IDLE on the reset edge and out_valid drops immediately. The partial frame is not completed; resynchronizing the consumer is the system's responsibility.

## Structure
- Shared package keylime_cmd_pkg holds:
  - the FSM state enum type;
  - the error codes STATUS_LEN_ERR=8'hFE and STATUS_TIMEOUT=8'hFF;
  - the frame-field constants.
- One sub-module: cmd_payload_buf, a MAX_LEN×8 register array with a sync write port and a comb read port indexed by the SEND_PL counter.
- The FSM, checksum accumulator and timeout counter live in cmd_initiator.

## Test plan
- Opcode 8'h61, len 0, out_ready=1:
  - Stream is 61, 00, 61 on consecutive cycles.
  - Inject reply 8'h00 → done pulse, status=00, timeout=0.
- Payload 01,02,03, opcode 8'h62, len 3:
  - Stream is 62, 03, 01, 02, 03, 61.
  - Reply 8'h5A → status=5A.
- Repeat the previous case with out_ready toggled pseudo-randomly:
  - Identical byte sequence, no duplicates or drops.
  - out_data stable during every stall.
- No reply after the frame → done and timeout=1 exactly TIMEOUT_CYCLES cycles after entering WAIT_RESP; status=FF.
- len=17 with MAX_LEN=16 → done with status=FE; out_valid never asserted.
- Reset asserted while sending payload byte 1 → next cycle out_valid=0, busy=0; cmd_ready=1 after reset releases.
- A fresh command after that reset completes normally.
